// File: rtl/seq_detector_param.sv
// ============================================================================
// seq_detector_param : programmable W-bit symbol sequence detector with
//                      overlap control and saturating match counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_detector_param #(
  parameter int W       = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 p,
  input  logic                         p_valid,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
  input  logic [W-1:0]                 cfg_sym,
  input  logic                         len_we,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         overlap,
  input  logic                         arm,
  input  logic                         disarm,
  input  logic                         clr_cnt,
  output logic                         y,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         armed
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN+1);

  typedef enum logic [0:0] {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [W-1:0]     pattern [MAX_LEN];
  logic [W-1:0]     hist    [MAX_LEN];
  logic [W-1:0]     hist_nx [MAX_LEN];
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_cnt;
  logic             accept;
  logic             enter_armed;
  logic             seq_eq;
  logic             match;

  always_comb begin
    state_nx = state;
    case (state)
      DISARMED: if (arm && (len != '0)) state_nx = ARMED;
      ARMED:    if (disarm)             state_nx = DISARMED;
      default:                          state_nx = DISARMED;
    endcase
  end

  assign armed       = (state == ARMED);
  assign accept      = (state == ARMED) && p_valid;
  assign enter_armed = (state == DISARMED) && (state_nx == ARMED);

  // hist[0] is the newest symbol; hist_nx is the history as it will look
  // once the current symbol is shifted in.
  assign hist_nx[0] = p;
  for (genvar k = 1; k < MAX_LEN; k++) begin : g_hist
    assign hist_nx[k] = hist[k-1];
  end

  assign fill_cnt = (fill < len) ? fill + LEN_W'(1) : fill;

  // Newest symbol lines up with pattern[len-1], the one before with len-2, ...
  always_comb begin
    seq_eq = 1'b1;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(len)) && (hist_nx[k] != pattern[IDX_W'(int'(len) - 1 - k)]))
        seq_eq = 1'b0;
    end
  end

  assign match = accept && (fill_cnt >= len) && seq_eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISARMED;
      len       <= '0;
      fill      <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
      for (int k = 0; k < MAX_LEN; k++) begin
        pattern[k] <= '0;
        hist[k]    <= '0;
      end
    end else begin
      state <= state_nx;
      y     <= match;

      if (clr_cnt)
        match_cnt <= '0;
      else if (match && (match_cnt != '1))
        match_cnt <= match_cnt + CNT_W'(1);

      if (state == DISARMED) begin
        if (cfg_we && (int'(cfg_idx) < MAX_LEN))
          pattern[cfg_idx] <= cfg_sym;
        if (len_we)
          len <= (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
      end

      if (enter_armed)
        fill <= '0;
      else if (accept)
        fill <= (match && !overlap) ? '0 : fill_cnt;

      if (accept) begin
        for (int k = 0; k < MAX_LEN; k++)
          hist[k] <= hist_nx[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// tb_seq_detector_param : scoreboard bench for seq_detector_param.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] p = '0;
  logic       p_valid = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [3:0] cfg_sym = '0;
  logic       len_we = 1'b0;
  logic [3:0] cfg_len = '0;
  logic       overlap = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       clr_cnt = 1'b0;
  logic        y, armed, y_s, armed_s;
  logic [15:0] match_cnt;
  logic [1:0]  cnt_s;

  seq_detector_param #(.W(4), .MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_sym(cfg_sym), .len_we(len_we), .cfg_len(cfg_len),
    .overlap(overlap), .arm(arm), .disarm(disarm), .clr_cnt(clr_cnt),
    .y(y), .match_cnt(match_cnt), .armed(armed));

  seq_detector_param #(.W(4), .MAX_LEN(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_sym(cfg_sym), .len_we(len_we), .cfg_len(cfg_len),
    .overlap(overlap), .arm(arm), .disarm(disarm), .clr_cnt(clr_cnt),
    .y(y_s), .match_cnt(cnt_s), .armed(armed_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        y;
    logic [15:0] cnt;
    logic        armed;
    logic        ys;
    logic        as;
    logic [1:0]  cs;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  int   total = 0;
  int   passed = 0;
  int   pulses;

  // Reference model state
  bit         m_armed = 0;
  int         m_len = 0;
  logic [3:0] m_pat [8] = '{default: 4'h0};
  logic [3:0] m_seq [$];
  int         m_cnt = 0;
  int         m_cnt2 = 0;

  task automatic tick();
    out_t e;
    bit   m, go;
    m = 0;
    if (rst) begin
      m_armed = 0; m_len = 0; m_cnt = 0; m_cnt2 = 0;
      m_seq.delete();
      for (int i = 0; i < 8; i++) m_pat[i] = 4'h0;
    end else begin
      if (m_armed && p_valid) begin
        m_seq.push_back(p);
        if (m_seq.size() > m_len) void'(m_seq.pop_front());
        if (m_seq.size() == m_len) begin
          m = 1;
          for (int i = 0; i < m_len; i++) if (m_seq[i] !== m_pat[i]) m = 0;
        end
        if (m && !overlap) m_seq.delete();
      end
      if (clr_cnt) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (m) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (!m_armed) begin
        go = arm && (m_len != 0);
        if (cfg_we) m_pat[cfg_idx] = cfg_sym;
        if (len_we) m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
        if (go) begin m_armed = 1; m_seq.delete(); end
      end else if (disarm) begin
        m_armed = 0;
      end
    end
    e.y = m; e.cnt = 16'(m_cnt); e.armed = m_armed;
    e.ys = m; e.as = m_armed; e.cs = 2'(m_cnt2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back({y, match_cnt, armed, y_s, armed_s, cnt_s});
    rst = 0; p_valid = 0; cfg_we = 0; len_we = 0; arm = 0; disarm = 0; clr_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick();
  endtask

  task automatic load(input logic [3:0] s0, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [3:0] n);
    cfg_we = 1; cfg_idx = 3'd0; cfg_sym = s0; tick();
    cfg_we = 1; cfg_idx = 3'd1; cfg_sym = s1; tick();
    cfg_we = 1; cfg_idx = 3'd2; cfg_sym = s2; tick();
    len_we = 1; cfg_len = n; tick();
  endtask

  task automatic feed(input logic [3:0] s, input logic v);
    p = s; p_valid = v; tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({y, match_cnt, armed} !== 18'd0) $display("FAIL reset_out: got y=%b cnt=%0d armed=%b, want 0/0/0", y, match_cnt, armed);
    else passed++;
    arm = 1; tick();
    total++;
    if (armed !== 1'b0) $display("FAIL arm_len0: got armed=%b, want 0", armed);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_reset: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    load(4'hA, 4'h8, 4'h7, 4'd3);
    overlap = 0; arm = 1; tick();
    feed(4'hA, 1); feed(4'h8, 1); feed(4'h7, 1);
    total++;
    if (y !== 1'b1 || match_cnt !== 16'd1) $display("FAIL basic_match: got y=%b cnt=%0d, want 1/1", y, match_cnt);
    else passed++;
    feed(4'h0, 1);
    total++;
    if (y !== 1'b0) $display("FAIL basic_pulse_width: got y=%b, want 0", y);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_basic: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load(4'hA, 4'hA, 4'h0, 4'd2);
    overlap = 1; arm = 1; tick();
    pulses = 0;
    repeat (3) begin feed(4'hA, 1); pulses += int'(y); end
    total++;
    if (pulses != 2 || match_cnt !== 16'd2) $display("FAIL overlap_on: got pulses=%0d cnt=%0d, want 2/2", pulses, match_cnt);
    else passed++;
    disarm = 1; tick();
    overlap = 0; arm = 1; tick();
    pulses = 0;
    repeat (3) begin feed(4'hA, 1); pulses += int'(y); end
    total++;
    if (pulses != 1 || match_cnt !== 16'd3) $display("FAIL overlap_off: got pulses=%0d cnt=%0d, want 1/3", pulses, match_cnt);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_b2b: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_recovery();
    do_reset();
    load(4'hA, 4'h8, 4'h7, 4'd3);
    overlap = 0; arm = 1; tick();
    pulses = 0;
    feed(4'hA, 1); pulses += int'(y);
    feed(4'hA, 1); pulses += int'(y);
    feed(4'h8, 1); pulses += int'(y);
    feed(4'h7, 1); pulses += int'(y);
    total++;
    if (pulses != 1) $display("FAIL recovery_aa87: got pulses=%0d, want 1", pulses);
    else passed++;
    pulses = 0;
    feed(4'hA, 1); pulses += int'(y);
    repeat (3) begin feed(4'h7, 0); pulses += int'(y); end
    feed(4'h8, 1); pulses += int'(y);
    feed(4'h7, 1); pulses += int'(y);
    total++;
    if (pulses != 1 || match_cnt !== 16'd2) $display("FAIL gap_ignored: got pulses=%0d cnt=%0d, want 1/2", pulses, match_cnt);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_recovery: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_armed_cfg();
    do_reset();
    load(4'hA, 4'h8, 4'h7, 4'd3);
    overlap = 0; arm = 1; tick();
    cfg_we = 1; cfg_idx = 3'd0; cfg_sym = 4'hF; tick();
    feed(4'hA, 1); feed(4'h8, 1); feed(4'h7, 1);
    total++;
    if (y !== 1'b1) $display("FAIL cfg_locked: got y=%b, want 1", y);
    else passed++;
    feed(4'hA, 1); feed(4'h8, 1);
    disarm = 1; tick();
    arm = 1; tick();
    feed(4'h7, 1);
    total++;
    if (y !== 1'b0) $display("FAIL rearm_clears_fill: got y=%b, want 0", y);
    else passed++;
    feed(4'hA, 1); feed(4'h8, 1);
    disarm = 1; feed(4'h7, 1);
    total++;
    if (y !== 1'b1 || armed !== 1'b0 || match_cnt !== 16'd2) $display("FAIL disarm_same_edge: got y=%b armed=%b cnt=%0d, want 1/0/2", y, armed, match_cnt);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_armed_cfg: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load(4'hA, 4'h0, 4'h0, 4'd1);
    overlap = 1; arm = 1; tick();
    repeat (5) feed(4'hA, 1);
    total++;
    if (cnt_s !== 2'd3 || match_cnt !== 16'd5) $display("FAIL saturate: got cnt2=%0d cnt=%0d, want 3/5", cnt_s, match_cnt);
    else passed++;
    clr_cnt = 1; feed(4'hA, 1);
    total++;
    if (y !== 1'b1 || match_cnt !== 16'd0 || cnt_s !== 2'd0) $display("FAIL clr_wins: got y=%b cnt=%0d cnt2=%0d, want 1/0/0", y, match_cnt, cnt_s);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_saturation: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    load(4'hA, 4'h8, 4'h7, 4'd3);
    arm = 1; tick();
    feed(4'hA, 1); feed(4'h8, 1);
    rst = 1; feed(4'h7, 1);
    total++;
    if ({y, match_cnt, armed} !== 18'd0) $display("FAIL rst_mid: got y=%b cnt=%0d armed=%b, want 0/0/0", y, match_cnt, armed);
    else passed++;
    arm = 1; tick();
    total++;
    if (armed !== 1'b0) $display("FAIL rst_clears_len: got armed=%b, want 0", armed);
    else passed++;
    while (exp_q.size() > 0) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL sb_rst_mid: got %h, want %h", o, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_recovery();
    test_armed_cfg();
    test_saturation();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
